// File: rtl/ats_token_bucket_gate.sv
// rtl/ats_token_bucket_gate.sv - token-bucket frame gate sequencing length and data streams for ATS egress
//
// Holds each frame until the bucket covers its length (read from the side stream),
// debits the bucket, then passes the frame through combinationally up to its tlast.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cfg_rate                      credit added per cycle (TOKEN_FRAC_BITS fractional bits)
//   cfg_burst                     bucket ceiling (same fixed-point format)
//   s_axis_frame_length_*         length side stream, MSB-first beats, tlast on final beat
//   s_axis_*                      frame bytes in
//   m_axis_*                      gated frame bytes out
//   length_error                  sticky: length tlast seen on the wrong beat
//   stat_frames/stat_oversize/stat_wait_cyc   32-bit counters, only with ATS_GATE_STATS_EN
//
// Optional feature macro: ATS_GATE_STATS_EN
module ats_token_bucket_gate #(
  parameter int DATA_WIDTH         = 8,
  parameter int FRAME_LENGTH_WIDTH = 16,
  parameter int TOKEN_FRAC_BITS    = 8,
  parameter int TOKEN_WIDTH        = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [TOKEN_WIDTH-1:0] cfg_rate,
  input  logic [TOKEN_WIDTH-1:0] cfg_burst,
  input  logic [DATA_WIDTH-1:0]  s_axis_frame_length_tdata,
  input  logic                   s_axis_frame_length_tvalid,
  output logic                   s_axis_frame_length_tready,
  input  logic                   s_axis_frame_length_tlast,
  input  logic [DATA_WIDTH-1:0]  s_axis_tdata,
  input  logic                   s_axis_tvalid,
  input  logic                   s_axis_tlast,
  output logic                   s_axis_tready,
  output logic [DATA_WIDTH-1:0]  m_axis_tdata,
  output logic                   m_axis_tvalid,
  output logic                   m_axis_tlast,
  input  logic                   m_axis_tready,
  output logic                   length_error
`ifdef ATS_GATE_STATS_EN
  ,
  output logic [31:0]            stat_frames,
  output logic [31:0]            stat_oversize,
  output logic [31:0]            stat_wait_cyc
`endif
);

  localparam int LEN_BEATS = FRAME_LENGTH_WIDTH / DATA_WIDTH;
  localparam int CNT_W     = (LEN_BEATS > 1) ? $clog2(LEN_BEATS) : 1;
  localparam int NEED_W    = FRAME_LENGTH_WIDTH + TOKEN_FRAC_BITS;
  // One spare bit so tokens + rate never wraps before the ceiling compare.
  localparam int CALC_W    = ((NEED_W > TOKEN_WIDTH) ? NEED_W : TOKEN_WIDTH) + 1;

  typedef enum logic [1:0] {
    ST_LEN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_PASS = 2'd2
  } state_t;

  state_t                    state;
  state_t                    state_next;
  logic [TOKEN_WIDTH-1:0]    tokens;
  logic [FRAME_LENGTH_WIDTH-1:0] len_reg;
  logic [CNT_W-1:0]          beat_cnt;
  logic                      ready_en;

  logic                      len_accept;
  logic                      len_last_beat;
  logic                      frame_done;
  logic                      covered;
  logic                      at_ceiling;
  logic                      eligible;
  logic                      debit;
  logic [CALC_W-1:0]         need_x;
  logic [CALC_W-1:0]         tokens_x;
  logic [CALC_W-1:0]         t1;
  logic [CALC_W-1:0]         t2;
  logic [TOKEN_WIDTH-1:0]    tokens_next;

  assign len_last_beat = (beat_cnt == CNT_W'(LEN_BEATS - 1));

  // Bucket arithmetic
  assign need_x     = CALC_W'(len_reg) << TOKEN_FRAC_BITS;
  assign tokens_x   = CALC_W'(tokens);
  assign covered    = (tokens_x >= need_x);
  // A full bucket releases the frame even if it cannot cover it, so frames
  // longer than the burst size do not stall the stream forever.
  assign at_ceiling = (tokens >= cfg_burst);
  assign eligible   = covered | at_ceiling;
  assign debit      = (state == ST_WAIT) & eligible;

  assign t1 = debit ? (covered ? (tokens_x - need_x) : '0) : tokens_x;
  assign t2 = t1 + CALC_W'(cfg_rate);
  // cfg_burst never exceeds the register maximum, so clamping to it also
  // covers the saturation at 2^TOKEN_WIDTH-1.
  assign tokens_next = (t2 >= CALC_W'(cfg_burst)) ? cfg_burst : t2[TOKEN_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_LEN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next                 = state;
    s_axis_frame_length_tready = 1'b0;
    s_axis_tready              = 1'b0;
    m_axis_tvalid              = 1'b0;
    m_axis_tdata               = s_axis_tdata;
    m_axis_tlast               = s_axis_tlast;
    len_accept                 = 1'b0;
    frame_done                 = 1'b0;
    case (state)
      ST_LEN: begin
        // ready_en keeps every handshake low in the first cycle out of reset.
        s_axis_frame_length_tready = ready_en;
        len_accept = s_axis_frame_length_tvalid & ready_en;
        if (len_accept && len_last_beat) begin
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (eligible) begin
          state_next = ST_PASS;
        end
      end
      ST_PASS: begin
        m_axis_tvalid = s_axis_tvalid;
        s_axis_tready = m_axis_tready;
        frame_done    = s_axis_tvalid & m_axis_tready & s_axis_tlast;
        if (frame_done) begin
          state_next = ST_LEN;
        end
      end
      default: begin
        state_next = ST_LEN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tokens       <= '0;
      len_reg      <= '0;
      beat_cnt     <= '0;
      length_error <= 1'b0;
      ready_en     <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      tokens   <= tokens_next;
      if (len_accept) begin
        len_reg <= (len_reg << DATA_WIDTH) | FRAME_LENGTH_WIDTH'(s_axis_frame_length_tdata);
        // The beat count decides where the length ends; tlast only flags errors.
        if (len_last_beat) begin
          beat_cnt <= '0;
        end else begin
          beat_cnt <= beat_cnt + CNT_W'(1);
        end
        if (s_axis_frame_length_tlast != len_last_beat) begin
          length_error <= 1'b1;
        end
      end
    end
  end

`ifdef ATS_GATE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_frames   <= '0;
      stat_oversize <= '0;
      stat_wait_cyc <= '0;
    end else begin
      if (frame_done) begin
        stat_frames <= stat_frames + 32'd1;
      end
      if (debit && !covered) begin
        stat_oversize <= stat_oversize + 32'd1;
      end
      if (state == ST_WAIT) begin
        stat_wait_cyc <= stat_wait_cyc + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ats_token_bucket_gate.sv
// tb/tb_ats_token_bucket_gate.sv - directed self-checking bench for ats_token_bucket_gate
module tb_ats_token_bucket_gate;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cfg_rate;
  logic [31:0] cfg_burst;
  logic [7:0]  flen_tdata;
  logic        flen_tvalid;
  logic        flen_tready;
  logic        flen_tlast;
  logic [7:0]  s_tdata;
  logic        s_tvalid;
  logic        s_tlast;
  logic        s_tready;
  logic [7:0]  m_tdata;
  logic        m_tvalid;
  logic        m_tlast;
  logic        m_tready;
  logic        length_error;

  int          cmp_cnt = 0;
  int          err_cnt = 0;
  int          stall;
  logic [31:0] tok0;

  ats_token_bucket_gate dut (
    .clk                        (clk),
    .rst                        (rst),
    .cfg_rate                   (cfg_rate),
    .cfg_burst                  (cfg_burst),
    .s_axis_frame_length_tdata  (flen_tdata),
    .s_axis_frame_length_tvalid (flen_tvalid),
    .s_axis_frame_length_tready (flen_tready),
    .s_axis_frame_length_tlast  (flen_tlast),
    .s_axis_tdata               (s_tdata),
    .s_axis_tvalid              (s_tvalid),
    .s_axis_tlast               (s_tlast),
    .s_axis_tready              (s_tready),
    .m_axis_tdata               (m_tdata),
    .m_axis_tvalid              (m_tvalid),
    .m_axis_tlast               (m_tlast),
    .m_axis_tready              (m_tready),
    .length_error               (length_error)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    cmp_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    flen_tvalid = 1'b0;
    flen_tlast = 1'b0;
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
    m_tready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_val({tag, "_rst_flen_tready"}, flen_tready, 0);
    check_val({tag, "_rst_s_tready"}, s_tready, 0);
    check_val({tag, "_rst_m_tvalid"}, m_tvalid, 0);
    check_val({tag, "_rst_tokens"}, dut.tokens, 0);
  endtask

  // Length beats MSB first; bad_last puts tlast on the first beat instead of the second.
  task automatic send_len(input logic [15:0] len, input bit bad_last);
    int t;
    for (int b = 0; b < 2; b++) begin
      flen_tdata  = (b == 0) ? len[15:8] : len[7:0];
      flen_tlast  = bad_last ? (b == 0) : (b == 1);
      flen_tvalid = 1'b1;
      #1;
      t = 0;
      while (!flen_tready && t < 50) begin
        @(negedge clk);
        #1;
        t++;
      end
      if (t >= 50) check_val("len_timeout", 1, 0);
      @(negedge clk);
    end
    flen_tvalid = 1'b0;
    flen_tlast  = 1'b0;
  endtask

  // Streams n bytes (seed + 7*i) and checks what leaves m_axis.
  // stall = cycles before the gate opens; first_tok = bucket on the first open cycle.
  task automatic send_frame(input string tag, input int n, input logic [7:0] seed,
                            input bit toggle, output int stall_o, output logic [31:0] first_tok);
    int i, cyc, rx_cnt, bad_data, bad_last, mirror_err;
    bit opened;
    logic [7:0] exp_b;
    i = 0; cyc = 0; rx_cnt = 0; bad_data = 0; bad_last = 0; mirror_err = 0;
    opened = 0; stall_o = 0; first_tok = '0;
    m_tready = 1'b1;
    s_tvalid = 1'b1;
    while (i < n && cyc < 5000) begin
      s_tdata = seed + 8'(i * 7);
      s_tlast = (i == n - 1);
      if (toggle) m_tready = (cyc % 2 == 0);
      #1;
      if (m_tvalid && !opened) begin
        opened = 1;
        first_tok = dut.tokens;
      end
      if (!opened) stall_o++;
      if (m_tvalid && s_tready != m_tready) mirror_err++;
      if (m_tvalid && m_tready) begin
        exp_b = seed + 8'(rx_cnt * 7);
        if (m_tdata != exp_b) bad_data++;
        if (m_tlast != (rx_cnt == n - 1)) bad_last++;
        rx_cnt++;
      end
      if (s_tvalid && s_tready) i++;
      @(negedge clk);
      cyc++;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    m_tready = 1'b1;
    check_val({tag, "_rx_count"}, rx_cnt, n);
    check_val({tag, "_rx_data_errs"}, bad_data, 0);
    check_val({tag, "_rx_tlast_errs"}, bad_last, 0);
    check_val({tag, "_ready_mirror_errs"}, mirror_err, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t;
    rst = 1'b1;
    cfg_rate = 32'h100;
    cfg_burst = 32'h100000;
    flen_tdata = '0; flen_tvalid = 1'b0; flen_tlast = 1'b0;
    s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b1;

    // 1: 64B frame from an empty bucket
    do_reset("t1");
    send_len(16'd64, 1'b0);
    send_frame("t1", 64, 8'h11, 1'b0, stall, tok0);
    check_val("t1_stall", stall, 62);
    check_val("t1_tokens_open", tok0, 32'h100);
    check_val("t1_length_error", length_error, 0);

    // 2: full bucket, four back-to-back 64B frames
    do_reset("t2");
    cfg_rate = 32'h100000;
    @(negedge clk);
    cfg_rate = 32'h100;
    check_val("t2_preload", dut.tokens, 32'h100000);
    for (int f = 0; f < 4; f++) begin
      send_len(16'd64, 1'b0);
      send_frame($sformatf("t2_f%0d", f), 64, 8'(8'h40 + f), 1'b0, stall, tok0);
      check_val($sformatf("t2_f%0d_stall", f), stall, 1);
      check_val($sformatf("t2_f%0d_tokens_open", f), tok0, 32'hFC100);
    end

    // 3: frame larger than burst released by the oversize guard
    cfg_burst = 32'h2000;
    do_reset("t3");
    send_len(16'd64, 1'b0);
    send_frame("t3", 64, 8'h23, 1'b0, stall, tok0);
    check_val("t3_stall", stall, 30);
    check_val("t3_tokens_open", tok0, 32'h100);
    check_val("t3_length_error", length_error, 0);

    // 4: length tlast on the wrong beat, length still taken from both beats
    send_len(16'd16, 1'b1);
    check_val("t4_length_error_set", length_error, 1);
    send_frame("t4", 16, 8'h5A, 1'b0, stall, tok0);
    check_val("t4_stall", stall, 1);
    check_val("t4_tokens_open", tok0, 32'h1100);
    check_val("t4_length_error_sticky", length_error, 1);

    // 5: output ready toggling every cycle
    send_len(16'd20, 1'b0);
    send_frame("t5", 20, 8'h77, 1'b1, stall, tok0);
    check_val("t5_stall", stall, 1);
    check_val("t5_tokens_open", tok0, 32'hD00);

    // 6: reset in the middle of a frame
    send_len(16'd8, 1'b0);
    s_tvalid = 1'b1; s_tdata = 8'hA5; s_tlast = 1'b0; m_tready = 1'b1;
    #1;
    t = 0;
    while (!m_tvalid && t < 50) begin
      @(negedge clk);
      #1;
      t++;
    end
    check_val("t6_reached_pass", m_tvalid, 1);
    @(negedge clk);
    check_val("t6_length_error_before", length_error, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_val("t6_flen_tready", flen_tready, 0);
    check_val("t6_s_tready", s_tready, 0);
    check_val("t6_m_tvalid", m_tvalid, 0);
    check_val("t6_tokens", dut.tokens, 0);
    check_val("t6_length_error", length_error, 0);
    @(negedge clk);
    #1;
    check_val("t6_back_in_len", flen_tready, 1);
    s_tvalid = 1'b0;

    // 7: zero-length frame passes at once and still runs to its tlast
    cfg_burst = 32'h1000;
    send_len(16'd0, 1'b0);
    send_frame("t7", 3, 8'h90, 1'b0, stall, tok0);
    check_val("t7_stall", stall, 1);

    // 8: rate 0 with burst 0, everything released by the oversize guard
    cfg_rate = 32'h0;
    cfg_burst = 32'h0;
    do_reset("t8");
    send_len(16'd100, 1'b0);
    send_frame("t8", 100, 8'h03, 1'b0, stall, tok0);
    check_val("t8_stall", stall, 1);
    check_val("t8_tokens_open", tok0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
